uart_tx_sniffer: RTL

//  Receives the SoC serial output (externalPins_uart_tx) and delivers each

---
 rtl/uart_sniff_pkg.sv | 26 ++
 rtl/uart_tx_sniffer_if.sv | 18 +
 rtl/sniff_fifo.sv | 72 +++++++
 rtl/uart_tx_sniffer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/uart_sniff_pkg.sv
// Shared types and sizing helpers for the UART TX sniffer.
// Contents:
//   rx_state_t  receive FSM states (IDLE, START, DATA, STOP, WAIT_HIGH)
//   BIT_CNT_W   bit-period counter width for the default 434 clocks/bit
//   PTR_W       FIFO address width for the default 16-entry FIFO
//   cnt_width() width helper for the parameterised instances (min 1 bit)
package uart_sniff_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 434;
    localparam int FIFO_DEPTH_DEF   = 16;
    localparam int BIT_CNT_W        = $clog2(CLKS_PER_BIT_DEF);
    localparam int PTR_W            = $clog2(FIFO_DEPTH_DEF);

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_sniffer_if.sv
// Character stream interface between the sniffer and its consumer.
// Handshake: out_valid means out_data holds the FIFO head; the consumer
// takes it on any rising clock edge where out_valid && out_ready are both
// high. out_data must not be relied upon while out_valid is low, although
// the sniffer keeps it stable at the last head value.
//   out_data   master->slave  character at the FIFO head
//   out_valid  master->slave  FIFO not empty
//   out_ready  slave->master  consumer accepts the head
interface uart_tx_sniffer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sniff_fifo.sv
// Synchronous character FIFO for the sniffer.
// Ports:
//   clock, reset  single clock, synchronous active-high reset
//   push          a character is offered this cycle
//   push_data     the offered character
//   pop_ready     consumer ready; a pop happens when head_valid is also high
//   head_data     head character, holds the last popped value while empty
//   head_valid    FIFO not empty
//   accepted      the offered character was stored this cycle
//   dropped       the offered character was lost (full, no pop)
module sniff_fifo
    import uart_sniff_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop_ready,
    output logic [DATA_BITS-1:0] head_data,
    output logic                 head_valid,
    output logic                 accepted,
    output logic                 dropped
);
    localparam int AW = cnt_width(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] last_head;
    logic                 empty, full, pop;

    // Extra wrap bit: equal pointers mean empty, equal addresses with
    // differing wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && pop_ready;

    // A pop frees the head slot in the same cycle, so full+push+pop is legal;
    // when full the write address equals the slot being vacated.
    assign accepted = push && (!full || pop);
    assign dropped  = push && full && !pop;

    assign head_valid = !empty;
    assign head_data  = empty ? last_head : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (accepted) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_head <= '0;
        end else begin
            if (accepted) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                last_head <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sniffer.sv
// UART receiver on the SoC serial output, feeding a character FIFO.
// Ports:
//   clock, reset  single clock, synchronous active-high reset
//   uart_line     asynchronous serial input, idles high
//   chars         character stream (out_data / out_valid / out_ready)
//   frame_err     one-cycle pulse when a stop bit is sampled low
//   overflow      sticky: a character was dropped on a full FIFO
//   busy          receive FSM not in IDLE
//   char_count    characters accepted into the FIFO, wraps at 2^32
//   dbg_state     current receive FSM state
module uart_tx_sniffer
    import uart_sniff_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     uart_line,
    uart_tx_sniffer_if.master        chars,
    output logic                     frame_err,
    output logic                     overflow,
    output logic                     busy,
    output logic [31:0]              char_count,
    output rx_state_t                dbg_state
);
    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int IDX_W = cnt_width(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sline;
    rx_state_t              state, state_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   push, sample_bit;
    logic                   fifo_accepted, fifo_dropped;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_line};
        end
    end
    assign sline = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!sline) state_next = START;
            START:     if (bit_cnt == HALF_LAST) state_next = sline ? IDLE : DATA;
            DATA:      if (bit_cnt == BIT_LAST && bit_idx == IDX_LAST) state_next = STOP;
            STOP:      if (bit_cnt == BIT_LAST) state_next = sline ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (sline) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and the synchronised line
    always_comb begin
        push       = 1'b0;
        frame_err  = 1'b0;
        sample_bit = 1'b0;
        busy       = (state != IDLE);
        if (state == STOP && bit_cnt == BIT_LAST) begin
            push      = sline;
            frame_err = !sline;
        end
        if (state == DATA && bit_cnt == BIT_LAST) begin
            sample_bit = 1'b1;
        end
    end
    assign dbg_state = state;

    // Bit timing and character assembly. bit_cnt restarts on every state
    // change and wraps each bit period while DATA persists.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state_next != state || bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_ONE;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (sample_bit) begin
                shreg[bit_idx] <= sline;
                bit_idx        <= bit_idx + IDX_ONE;
            end
        end
    end

    // Statistics: only stored characters are counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            char_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (fifo_accepted) begin
                char_count <= char_count + 32'd1;
            end
            if (fifo_dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    logic [DATA_BITS-1:0] head_data;
    logic                 head_valid;

    sniff_fifo #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (shreg),
        .pop_ready (chars.out_ready),
        .head_data (head_data),
        .head_valid(head_valid),
        .accepted  (fifo_accepted),
        .dropped   (fifo_dropped)
    );

    assign chars.out_data  = head_data;
    assign chars.out_valid = head_valid;

endmodule
